// File: rtl/wb_ic_pkg.sv
// rtl/wb_ic_pkg.sv - shared types and constants for the 1xN Wishbone interconnect
package wb_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DECERR,
    ST_ABORT
  } ic_state_t;

  // Wide enough for 16 slaves plus a distinct "nobody selected" code.
  localparam int IDX_W = 5;
  typedef logic [IDX_W-1:0] slave_idx_t;
  localparam slave_idx_t NO_SLAVE = 5'h1f;

  localparam int RANGE_AW = 32;
  typedef struct packed {
    logic [RANGE_AW-1:0] base;
    logic [RANGE_AW-1:0] limit;
  } addr_range_t;

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - Wishbone B4 bus bundle with master and slave views
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_w;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport slave  (input cyc, stb, we, adr, cti, bte, dat_w, sel, output dat_r, ack, err);
  modport master (output cyc, stb, we, adr, cti, bte, dat_w, sel, input dat_r, ack, err);
endinterface

// File: rtl/wb_ic_addr_decode.sv
// rtl/wb_ic_addr_decode.sv - combinational range decoder, lowest slave index wins
module wb_ic_addr_decode
  import wb_ic_pkg::*;
#(
  parameter int AW       = 32,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES*2*AW-1:0] ADDR_RANGES = '0
) (
  input  logic [AW-1:0] adr,
  output slave_idx_t    idx,
  output logic          hit
);

  logic [AW-1:0] base;
  logic [AW-1:0] limit;

  // Scan from the highest index down so the lowest matching index is the last write.
  always_comb begin
    idx   = NO_SLAVE;
    hit   = 1'b0;
    base  = '0;
    limit = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      base  = ADDR_RANGES[(N_SLAVES-i)*2*AW-1 -: AW];
      limit = ADDR_RANGES[(N_SLAVES-i)*2*AW-AW-1 -: AW];
      // Offset form gives an inclusive check without a compare against a zero base.
      if ((adr - base) <= (limit - base)) begin
        idx = slave_idx_t'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_1xn.sv
// rtl/wb_interconnect_1xn.sv - single-master Wishbone interconnect to N slaves with decode error and watchdog
module wb_interconnect_1xn
  import wb_ic_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_SLAVES       = 4,
  parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  wb_if.slave                                    m0,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      sadr,
  output logic [N_SLAVES*3-1:0]                  scti,
  output logic [N_SLAVES*2-1:0]                  sbte,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      sdat_w,
  output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]  ssel,
  output logic [N_SLAVES-1:0]                    swe,
  output logic [N_SLAVES-1:0]                    scyc,
  output logic [N_SLAVES-1:0]                    sstb,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      sdat_r,
  input  logic [N_SLAVES-1:0]                    sack,
  input  logic [N_SLAVES-1:0]                    serr,
  output logic                                   timeout_evt
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ic_state_t  state_q, state_d;
  slave_idx_t sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  slave_idx_t dec_idx;
  logic       dec_hit;
  logic       sel_ack, sel_err, stall;
  logic [WB_DATA_WIDTH-1:0] sel_dat;
  logic       ack_o, err_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;

  wb_ic_addr_decode #(
    .AW          (WB_ADDR_WIDTH),
    .N_SLAVES    (N_SLAVES),
    .ADDR_RANGES (ADDR_RANGES)
  ) u_dec (
    .adr (m0.adr),
    .idx (dec_idx),
    .hit (dec_hit)
  );

  assign sadr   = {N_SLAVES{m0.adr}};
  assign scti   = {N_SLAVES{m0.cti}};
  assign sbte   = {N_SLAVES{m0.bte}};
  assign sdat_w = {N_SLAVES{m0.dat_w}};
  assign ssel   = {N_SLAVES{m0.sel}};
  assign swe    = {N_SLAVES{m0.we}};

  assign m0.ack   = ack_o;
  assign m0.err   = err_o;
  assign m0.dat_r = dat_o;

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == slave_idx_t'(i)) begin
        sel_ack = sack[i];
        sel_err = serr[i];
        sel_dat = sdat_r[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= NO_SLAVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = '0;
    scyc        = '0;
    sstb        = '0;
    ack_o       = 1'b0;
    err_o       = 1'b0;
    dat_o       = '0;
    timeout_evt = 1'b0;
    stall       = m0.stb && !sel_ack && !sel_err;
    unique case (state_q)
      ST_IDLE: begin
        if (m0.cyc && m0.stb) begin
          if (dec_hit) begin
            state_d = ST_ACTIVE;
            sel_d   = dec_idx;
          end else begin
            state_d = ST_DECERR;
          end
        end
      end
      ST_ACTIVE: begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (sel_q == slave_idx_t'(i)) begin
            scyc[i] = m0.cyc;
            sstb[i] = m0.stb;
          end
        end
        ack_o = sel_ack;
        err_o = sel_err;
        dat_o = sel_dat;
        if (!stall)                cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        else                       cnt_d = cnt_q;
        // Master releasing the bus outranks any response or watchdog expiry.
        if (!m0.cyc) begin
          state_d = ST_IDLE;
          sel_d   = NO_SLAVE;
        end else if (TIMEOUT_CYCLES != 0 && stall && cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
          sel_d   = NO_SLAVE;
        end
      end
      ST_DECERR: begin
        err_o   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        err_o       = 1'b1;
        timeout_evt = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// tb/tb_wb_interconnect_1xn.sv - directed scoreboard bench for wb_interconnect_1xn
module tb_wb_interconnect_1xn;
  import wb_ic_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  localparam addr_range_t RA0 = '{base: 32'h0000, limit: 32'h0FFF};
  localparam addr_range_t RA1 = '{base: 32'h1000, limit: 32'h1FFF};
  localparam addr_range_t RA2 = '{base: 32'h2000, limit: 32'h2FFF};
  localparam addr_range_t RA3 = '{base: 32'h3000, limit: 32'h3FFF};
  localparam addr_range_t RB0 = '{base: 32'h0000, limit: 32'h1FFF};
  localparam logic [NS*2*AW-1:0] RANGES_A = {RA0, RA1, RA2, RA3};
  localparam logic [NS*2*AW-1:0] RANGES_B = {RB0, RA1, RA2, RA3};

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        tevt;
  } resp_t;

  logic clk, rst;
  wb_if #(.AW(AW), .DW(DW)) ma ();
  wb_if #(.AW(AW), .DW(DW)) mb ();

  logic [NS*AW-1:0]     sadr_a, sadr_b;
  logic [NS*3-1:0]      scti_a, scti_b;
  logic [NS*2-1:0]      sbte_a, sbte_b;
  logic [NS*DW-1:0]     sdat_w_a, sdat_w_b, sdat_r_a, sdat_r_b;
  logic [NS*DW/8-1:0]   ssel_a, ssel_b;
  logic [NS-1:0]        swe_a, swe_b, scyc_a, scyc_b, sstb_a, sstb_b;
  logic [NS-1:0]        sack_a, sack_b, serr_a, serr_b;
  logic                 tevt_a, tevt_b;

  logic [NS-1:0] ack_en, force_ack;
  logic          use_b;
  logic          mon_ack, mon_err, mon_tevt;
  logic [31:0]   mon_dat;

  resp_t exp_q[$];
  int    checks, errors;

  wb_interconnect_1xn #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_SLAVES(NS),
    .ADDR_RANGES(RANGES_A), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst), .m0(ma),
    .sadr(sadr_a), .scti(scti_a), .sbte(sbte_a), .sdat_w(sdat_w_a), .ssel(ssel_a), .swe(swe_a),
    .scyc(scyc_a), .sstb(sstb_a), .sdat_r(sdat_r_a), .sack(sack_a), .serr(serr_a),
    .timeout_evt(tevt_a)
  );

  wb_interconnect_1xn #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_SLAVES(NS),
    .ADDR_RANGES(RANGES_B), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst(rst), .m0(mb),
    .sadr(sadr_b), .scti(scti_b), .sbte(sbte_b), .sdat_w(sdat_w_b), .ssel(ssel_b), .swe(swe_b),
    .scyc(scyc_b), .sstb(sstb_b), .sdat_r(sdat_r_b), .sack(sack_b), .serr(serr_b),
    .timeout_evt(tevt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] slave_data(input int i, input logic [31:0] adr);
    return (i == 1) ? 32'hA5A5A5A5 : {8'h50 + 8'(i), adr[23:0]};
  endfunction

  // Zero-wait slaves: ACK in the same cycle they see CYC&STB, unless disabled.
  always_comb begin
    sack_a   = '0;
    sack_b   = '0;
    sdat_r_a = '0;
    sdat_r_b = '0;
    for (int i = 0; i < NS; i++) begin
      sack_a[i] = (scyc_a[i] & sstb_a[i] & ack_en[i]) | force_ack[i];
      sack_b[i] = scyc_b[i] & sstb_b[i] & ack_en[i];
      sdat_r_a[i*DW +: DW] = slave_data(i, sadr_a[i*AW +: AW]);
      sdat_r_b[i*DW +: DW] = slave_data(i, sadr_b[i*AW +: AW]);
    end
  end
  assign serr_a = '0;
  assign serr_b = '0;

  assign mon_ack  = use_b ? mb.ack   : ma.ack;
  assign mon_err  = use_b ? mb.err   : ma.err;
  assign mon_dat  = use_b ? mb.dat_r : ma.dat_r;
  assign mon_tevt = use_b ? tevt_b   : tevt_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    ma.cyc = cyc;  mb.cyc = cyc;
    ma.stb = stb;  mb.stb = stb;
    ma.we  = we;   mb.we  = we;
    ma.adr = adr;  mb.adr = adr;
    ma.cti = cti;  mb.cti = cti;
    ma.bte = 2'b00; mb.bte = 2'b00;
    ma.dat_w = adr ^ 32'h5555_0000; mb.dat_w = adr ^ 32'h5555_0000;
    ma.sel = 4'hF; mb.sel = 4'hF;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    resp_t e;
    int    n;
    n = 0;
    while (!(mon_ack || mon_err) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " queue nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, " ack"},  mon_ack,  e.ack);
      chk({tag, " err"},  mon_err,  e.err);
      chk({tag, " data"}, mon_dat,  e.dat);
      chk({tag, " tevt"}, mon_tevt, e.tevt);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    use_b     = 1'b0;
    ack_en    = 4'b1111;
    force_ack = 4'b0000;
    rst       = 1'b1;
    drive(0, 0, 0, 32'h0, 3'b000);

    // Reset state
    tick(); tick();
    chk("rst scyc", scyc_a, 0);
    chk("rst sstb", sstb_a, 0);
    chk("rst ack", ma.ack, 0);
    chk("rst err", ma.err, 0);
    chk("rst tevt", tevt_a, 0);
    rst = 1'b0;
    tick();

    // Decode hit: read 0x1004 -> slave 1 one cycle later
    drive(1, 1, 0, 32'h1004, 3'b000);
    exp_q.push_back('{1'b1, 1'b0, 32'hA5A5A5A5, 1'b0});
    settle();
    chk("hit req-cycle scyc", scyc_a, 0);
    wait_resp("hit", 1);
    chk("hit scyc", scyc_a, 4'b0010);
    chk("hit sstb", sstb_a, 4'b0010);
    chk("hit sadr bcast", sadr_a[1*AW +: AW], 32'h1004);
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();
    chk("hit release scyc", scyc_a, 0);

    // Decode miss: write 0x9000_0000 -> one-cycle ERR, no strobe
    drive(1, 1, 1, 32'h9000_0000, 3'b000);
    exp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
    settle();
    chk("miss req-cycle err", ma.err, 0);
    wait_resp("miss", 1);
    chk("miss sstb", sstb_a, 0);
    chk("miss scyc", scyc_a, 0);
    chk("miss swe bcast", swe_a, 4'b1111);
    chk("miss dat_w bcast", sdat_w_a[3*DW +: DW], 32'hC555_0000);
    chk("miss sel bcast", ssel_a, 16'hFFFF);
    chk("miss bte bcast", sbte_a, 0);
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();
    chk("miss err one cycle", ma.err, 0);

    // Watchdog: slave 2 never ACKs
    ack_en = 4'b1011;
    drive(1, 1, 0, 32'h2000, 3'b000);
    exp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b1});
    settle();
    repeat (8) tick();
    chk("stall8 scyc", scyc_a, 4'b0100);
    chk("stall8 err", ma.err, 0);
    wait_resp("timeout", 1);
    chk("abort scyc", scyc_a, 0);
    force_ack = 4'b0100;
    settle();
    chk("abort late ack", ma.ack, 0);
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();
    chk("post-abort ack", ma.ack, 0);
    chk("post-abort err", ma.err, 0);
    chk("post-abort tevt", tevt_a, 0);
    force_ack = 4'b0000;

    // CYC drops in the cycle the watchdog would fire
    drive(1, 1, 0, 32'h2000, 3'b000);
    settle();
    repeat (8) tick();
    chk("simul pre err", ma.err, 0);
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();
    chk("simul err", ma.err, 0);
    chk("simul tevt", tevt_a, 0);
    chk("simul state", 32'(dut_a.state_q), 32'(ST_IDLE));
    tick();
    chk("simul tevt later", tevt_a, 0);

    // Reset mid-ACTIVE
    ack_en = 4'b0111;
    drive(1, 1, 0, 32'h3004, 3'b000);
    settle();
    tick();
    chk("pre-rst scyc", scyc_a, 4'b1000);
    rst = 1'b1;
    settle();
    chk("mid-rst scyc", scyc_a, 0);
    chk("mid-rst tevt", tevt_a, 0);
    tick();
    rst = 1'b0;
    ack_en = 4'b1111;
    drive(1, 1, 0, 32'h1004, 3'b000);
    exp_q.push_back('{1'b1, 1'b0, 32'hA5A5A5A5, 1'b0});
    settle();
    chk("post-rst idle scyc", scyc_a, 0);
    wait_resp("post-rst", 1);
    chk("post-rst scyc", scyc_a, 4'b0010);
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();

    // Overlapping ranges, burst crossing 0x1000 stays on slave 0
    use_b = 1'b1;
    drive(1, 1, 0, 32'h0FF8, 3'b010);
    exp_q.push_back('{1'b1, 1'b0, 32'h5000_0FF8, 1'b0});
    settle();
    wait_resp("burst0", 1);
    chk("burst0 scyc", scyc_b, 4'b0001);
    chk("burst0 cti bcast", scti_b[2:0], 3'b010);
    for (int b = 1; b < 4; b++) begin
      logic [31:0] a;
      a = 32'h0FF8 + 32'(4 * b);
      tick();
      drive(1, 1, 0, a, (b == 3) ? 3'b111 : 3'b010);
      exp_q.push_back('{1'b1, 1'b0, {8'h50, a[23:0]}, 1'b0});
      settle();
      wait_resp($sformatf("burst%0d", b), 0);
      chk($sformatf("burst%0d scyc", b), scyc_b, 4'b0001);
    end
    drive(0, 0, 0, 32'h0, 3'b000);
    tick();
    chk("burst end scyc", scyc_b, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_1xn.md
WB_INTERCONNECT_1XN -- requirements
Module: wb_interconnect_1xn

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter N_SLAVES, default 4, slave count, range 1..16.
REQ-004 SHALL have parameter ADDR_RANGES, default all-zero, packed {base,limit} pairs with slave 0 most significant, inclusive ranges.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit; 0 disables the watchdog.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port m0, wb_if.slave, -, the master port.
REQ-009 SHALL have ports sadr/scti/sbte/sdat_w/ssel/swe, output, N_SLAVES x field width packed, slave request fields.
REQ-010 SHALL have ports scyc/sstb, output, N_SLAVES, per-slave CYC and STB.
REQ-011 SHALL have ports sdat_r (N_SLAVES x WB_DATA_WIDTH), sack, serr (N_SLAVES), input, slave responses.
REQ-012 SHALL have port timeout_evt, output, 1, one-cycle pulse on watchdog abort.

Function
REQ-013 SHALL implement FSM states IDLE, ACTIVE, DECERR, ABORT.
REQ-014 IDLE: on m0.CYC&m0.STB, SHALL decode m0.ADR against all ranges and register the index; lowest index wins on overlap.
REQ-015 IDLE with hit SHALL go to ACTIVE; the slave sees CYC/STB on the next cycle (1 cycle added request latency).
REQ-016 IDLE with miss SHALL go to DECERR.
REQ-017 ACTIVE SHALL drive scyc/sstb of the selected slave from m0.CYC/m0.STB; all other scyc/sstb SHALL be 0.
REQ-018 ACTIVE SHALL broadcast ADR/CTI/BTE/DAT_W/SEL/WE to every slave.
REQ-019 ACTIVE SHALL return the selected slave's ACK/ERR/DAT_R combinationally to m0.
REQ-020 SHALL keep the selection locked for the whole master cycle, including bursts crossing range limits.
REQ-021 ACTIVE SHALL go to IDLE when m0.CYC=0.
REQ-022 DECERR SHALL assert m0.ERR for exactly one cycle with m0.DAT_R=0, then go to IDLE; no slave is strobed.
REQ-023 In ACTIVE, the watchdog counter SHALL clear on any selected ACK/ERR or when STB=0, and increment otherwise.
REQ-024 When the counter equals TIMEOUT_CYCLES, SHALL go to ABORT.
REQ-025 ABORT SHALL deassert all scyc/sstb, assert m0.ERR and timeout_evt for one cycle, then go to IDLE.
REQ-026 A late ACK/ERR from the aborted slave SHALL be ignored.
REQ-027 The watchdog counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and SHALL saturate, never wrap.
REQ-028 Outside ACTIVE, m0.ACK SHALL be 0.
REQ-029 Outside DECERR and ABORT, m0.ERR SHALL come only from the selected slave.
REQ-030 If m0.CYC drops in the same cycle as ACK/ERR or timeout, dropping CYC SHALL take priority and the next state SHALL be IDLE with no ERR pulse.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, the selection to NO_SLAVE, the counter to 0, and all scyc/sstb, m0.ACK, m0.ERR and timeout_evt to 0.
REQ-032 rst asserted mid-transfer SHALL drop slave CYC immediately; after reset release the first master request SHALL be re-decoded.

Structure
REQ-033 The FSM state enum, NO_SLAVE constant and range-pair typedef SHALL live in package wb_ic_pkg.
REQ-034 Address decode SHALL be a sub-module wb_ic_addr_decode (combinational, parametrised on N_SLAVES and ADDR_RANGES, outputs index and hit).

Verification
REQ-035 Reset: assert rst mid-ACTIVE -> all scyc=0 that cycle; next request re-decoded; timeout_evt=0.
REQ-036 Decode hit: N_SLAVES=4, ranges 0x0-0xFFF, 0x1000-0x1FFF, ...; read 0x1004 -> scyc[1] one cycle after STB; ACK and DAT_R=0xA5A5A5A5 returned to m0.
REQ-037 Decode miss: write 0x9000_0000 -> no sstb asserted; m0.ERR high exactly one cycle after request.
REQ-038 Overlap/burst: slave0 0x0-0x1FFF, slave1 0x1000-0x1FFF; 4-beat burst from 0xFF8 -> slave0 only for all beats.
REQ-039 Timeout: TIMEOUT_CYCLES=8, slave never ACKs -> ERR and timeout_evt after 8 stalled cycles; later ACK ignored.
REQ-040 Simultaneous events: m0.CYC drops in the same cycle as the timeout -> no ERR; state IDLE.
